ip_tx: RTL and testbench

IPv4 transmit stage directly downstream of the UDP transmit block. It accepts a UDP segment stream (UDP header plus payload) with per-packet metadata on the user sideband. It prepends a 20-byte IPv4 header with a computed header checksum, re-aligns the payload by 4 bytes on the 64-bit bus, and presents the IP datagram to the MAC/ARP transmit stage.

---
 rtl/ip_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_ip_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tx.sv
`default_nettype none
// ============================================================================
// Module   : ip_tx
// Purpose  : IPv4 transmit stage. Prepends a 20-byte IPv4 header (with header
//            checksum) to a UDP segment stream and re-aligns the payload by
//            4 bytes on the 64-bit bus before handing it to the MAC/ARP stage.
// Revision : 1.0 - initial release
// ============================================================================
module ip_tx #(
  parameter logic [31:0] P_SRC_IP = 32'hC0A86463,
  parameter logic [31:0] P_DST_IP = 32'hC0A86464,
  parameter logic [7:0]  P_TTL    = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dymanic_src_ip,
  input  logic        i_dymanic_src_valid,
  input  logic [31:0] i_dymanic_dst_ip,
  input  logic        i_dymanic_dst_valid,
  input  logic [63:0] s_axis_udp_data,
  input  logic [55:0] s_axis_udp_user,
  input  logic [7:0]  s_axis_udp_keep,
  input  logic        s_axis_udp_last,
  input  logic        s_axis_udp_valid,
  output logic        s_axis_udp_ready,
  output logic [63:0] m_axis_mac_data,
  output logic [31:0] m_axis_mac_user,
  output logic [7:0]  m_axis_mac_keep,
  output logic        m_axis_mac_last,
  output logic        m_axis_mac_valid,
  input  logic        m_axis_mac_ready
);

  localparam logic [15:0] c_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] c_ETHERTYPE   = 16'h0800;
  localparam logic [15:0] c_HDR_BYTES   = 16'd20;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CSUM = 3'd1,
    S_HDR0 = 3'd2,
    S_HDR1 = 3'd3,
    S_DATA = 3'd4,
    S_TAIL = 3'd5
  } state_t;

  state_t      r_state;

  // Live addresses (software-updatable) and the per-packet snapshot.
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [31:0] r_pkt_src;
  logic [31:0] r_pkt_dst;
  logic [55:0] r_pkt_user;

  logic [15:0] r_csum;
  logic [15:0] r_total_len;

  // Low half of the previous beat, waiting to become the high half of the
  // next output word. Seeded with the destination IP so the first payload
  // word naturally finishes the header.
  logic [31:0] r_hold_data;
  logic [3:0]  r_hold_keep;

  logic [63:0] r_m_data;
  logic [31:0] r_m_user;
  logic [7:0]  r_m_keep;
  logic        r_m_last;
  logic        r_m_valid;

  logic [15:0] w_len;
  logic [2:0]  w_flag;
  logic [7:0]  w_proto;
  logic [12:0] w_offset;
  logic [15:0] w_id;
  logic [15:0] w_total_len;
  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [15:0] w_csum;
  logic        w_load;
  logic        w_wait_last;
  logic        w_s_ready;
  logic        w_accept;
  logic [63:0] w_beat_data;
  logic [7:0]  w_beat_keep;

  assign w_len    = r_pkt_user[55:40];
  assign w_flag   = r_pkt_user[39:37];
  assign w_proto  = r_pkt_user[36:29];
  assign w_offset = r_pkt_user[28:16];
  assign w_id     = r_pkt_user[15:0];

  assign w_total_len = w_len + c_HDR_BYTES;

  // One's-complement header sum with the checksum field taken as zero.
  assign w_sum = {4'h0, c_VER_IHL_TOS}
               + {4'h0, w_total_len}
               + {4'h0, w_id}
               + {4'h0, w_flag, w_offset}
               + {4'h0, P_TTL, w_proto}
               + {4'h0, r_pkt_src[31:16]}
               + {4'h0, r_pkt_src[15:0]}
               + {4'h0, r_pkt_dst[31:16]}
               + {4'h0, r_pkt_dst[15:0]};
  assign w_fold1 = {1'b0, w_sum[15:0]} + {13'h0, w_sum[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};
  assign w_csum  = ~w_fold2;

  // Output register may take a new word when it is empty or being drained.
  assign w_load      = !r_m_valid || m_axis_mac_ready;
  // A final word is sitting in the output register; no more input this packet.
  assign w_wait_last = r_m_valid && r_m_last;
  // The first payload beat is taken as soon as W1 drains so there is no bubble.
  assign w_s_ready   = ((r_state == S_HDR1) || ((r_state == S_DATA) && !w_wait_last)) && w_load;
  assign w_accept    = s_axis_udp_valid && w_s_ready;

  assign w_beat_data = {r_hold_data, s_axis_udp_data[63:32]};
  assign w_beat_keep = {r_hold_keep, s_axis_udp_keep[7:4]};

  // Dynamic address registers, writable at any time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_ip <= P_SRC_IP;
      r_dst_ip <= P_DST_IP;
    end else begin
      if (i_dymanic_src_valid) r_src_ip <= i_dymanic_src_ip;
      if (i_dymanic_dst_valid) r_dst_ip <= i_dymanic_dst_ip;
    end
  end

  // Packet FSM with registered output stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pkt_src   <= P_SRC_IP;
      r_pkt_dst   <= P_DST_IP;
      r_pkt_user  <= 56'h0;
      r_csum      <= 16'h0;
      r_total_len <= 16'h0;
      r_hold_data <= 32'h0;
      r_hold_keep <= 4'h0;
      r_m_data    <= 64'h0;
      r_m_user    <= 32'h0;
      r_m_keep    <= 8'h00;
      r_m_last    <= 1'b0;
      r_m_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_axis_udp_valid) begin
            r_pkt_user <= s_axis_udp_user;
            r_pkt_src  <= r_src_ip;
            r_pkt_dst  <= r_dst_ip;
            r_state    <= S_CSUM;
          end
        end

        // Output register is always empty here, so W0 (which needs no
        // checksum) is loaded in the same cycle the checksum is computed.
        S_CSUM: begin
          r_csum      <= w_csum;
          r_total_len <= w_total_len;
          r_hold_data <= r_pkt_dst;
          r_hold_keep <= 4'hF;
          r_m_data    <= {c_VER_IHL_TOS, w_total_len, w_id, w_flag, w_offset};
          r_m_user    <= {w_total_len, c_ETHERTYPE};
          r_m_keep    <= 8'hFF;
          r_m_last    <= 1'b0;
          r_m_valid   <= 1'b1;
          r_state     <= S_HDR0;
        end

        S_HDR0: begin
          if (w_load) begin
            r_m_data  <= {P_TTL, w_proto, r_csum, r_pkt_src};
            r_m_keep  <= 8'hFF;
            r_m_valid <= 1'b1;
            r_state   <= S_HDR1;
          end
        end

        S_HDR1, S_DATA: begin
          if (w_wait_last) begin
            if (m_axis_mac_ready) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= S_IDLE;
            end
          end else if (w_accept) begin
            r_m_data    <= w_beat_data;
            r_m_keep    <= w_beat_keep;
            r_m_valid   <= 1'b1;
            r_hold_data <= s_axis_udp_data[31:0];
            r_hold_keep <= s_axis_udp_keep[3:0];
            if (s_axis_udp_last && !s_axis_udp_keep[3]) begin
              r_m_last <= 1'b1;
              r_state  <= S_DATA;
            end else if (s_axis_udp_last) begin
              r_m_last <= 1'b0;
              r_state  <= S_TAIL;
            end else begin
              r_m_last <= 1'b0;
              r_state  <= S_DATA;
            end
          end else if (w_load) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_state   <= S_DATA;
          end
        end

        // Flush the held low half once, then wait for it to be accepted.
        S_TAIL: begin
          if (r_m_last) begin
            if (m_axis_mac_ready) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= S_IDLE;
            end
          end else if (w_load) begin
            r_m_data  <= {r_hold_data, 32'h0};
            r_m_keep  <= {r_hold_keep, 4'h0};
            r_m_last  <= 1'b1;
            r_m_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axis_udp_ready = w_s_ready;
  assign m_axis_mac_data  = r_m_data;
  assign m_axis_mac_user  = r_m_user;
  assign m_axis_mac_keep  = r_m_keep;
  assign m_axis_mac_last  = r_m_last;
  assign m_axis_mac_valid = r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_tx
// Purpose  : Directed self-checking bench for ip_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dyn_src_ip;
  logic        dyn_src_valid;
  logic [31:0] dyn_dst_ip;
  logic        dyn_dst_valid;
  logic [63:0] s_data;
  logic [55:0] s_user;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [31:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit bp_en    = 1'b0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] u;
    int          c;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  ip_tx dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_dymanic_src_ip    (dyn_src_ip),
    .i_dymanic_src_valid (dyn_src_valid),
    .i_dymanic_dst_ip    (dyn_dst_ip),
    .i_dymanic_dst_valid (dyn_dst_valid),
    .s_axis_udp_data     (s_data),
    .s_axis_udp_user     (s_user),
    .s_axis_udp_keep     (s_keep),
    .s_axis_udp_last     (s_last),
    .s_axis_udp_valid    (s_valid),
    .s_axis_udp_ready    (s_ready),
    .m_axis_mac_data     (m_data),
    .m_axis_mac_user     (m_user),
    .m_axis_mac_keep     (m_keep),
    .m_axis_mac_last     (m_last),
    .m_axis_mac_valid    (m_valid),
    .m_axis_mac_ready    (m_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high, or random when backpressure is enabled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_ready = ($urandom_range(0, 1) == 1);
      else       m_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture accepted output beats and verify stability while stalled.
  logic        stall_prev = 1'b0;
  logic [104:0] stall_val;
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        beat_t b;
        b.d = m_data; b.k = m_keep; b.l = m_last; b.u = m_user; b.c = cyc;
        q.push_back(b);
      end
      if (stall_prev && !rst)
        chk("stall_hold", {23'h0, m_valid, m_data, m_keep, m_last, m_user},
                          {23'h0, 1'b1, stall_val});
      stall_prev = m_valid && !m_ready && !rst;
      stall_val  = {m_data, m_keep, m_last, m_user};
    end
  end

  function automatic logic [55:0] mk_user(input logic [15:0] len, input logic [2:0] flag,
                                          input logic [7:0] proto, input logic [12:0] off,
                                          input logic [15:0] id);
    return {len, flag, proto, off, id};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int  n    = 0;
    bit  done = 1'b0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    while (!done && n < 300) begin
      #8;
      done = (s_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("beat_accept", {127'h0, done}, 128'h1);
  endtask

  task automatic send_pkt16();
    send_beat(64'h1011121314151617, 8'hFF, 1'b0);
    send_beat(64'h18191A1B1C1D1E1F, 8'hFF, 1'b1);
  endtask

  task automatic expect_beats(input int n, input string tag);
    int waited = 0;
    while (q.size() < n && waited < 600) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("%s_count", tag), 128'(q.size()), 128'(n));
  endtask

  task automatic check_beat(input int idx, input string tag, input logic [63:0] d,
                            input logic [7:0] k, input logic l, input logic [31:0] u);
    logic [127:0] obs;
    obs = 'x;
    if (idx < q.size()) obs = {23'h0, q[idx].d, q[idx].k, q[idx].l, q[idx].u};
    chk($sformatf("%s_w%0d", tag, idx), obs, {23'h0, d, k, l, u});
  endtask

  task automatic check_pkt16(input logic [63:0] w1, input string tag);
    check_beat(0, tag, 64'h4500_0024_0000_4000, 8'hFF, 1'b0, 32'h0024_0800);
    check_beat(1, tag, w1,                      8'hFF, 1'b0, 32'h0024_0800);
    check_beat(2, tag, 64'hC0A8_6464_1011_1213, 8'hFF, 1'b0, 32'h0024_0800);
    check_beat(3, tag, 64'h1415_1617_1819_1A1B, 8'hFF, 1'b0, 32'h0024_0800);
    check_beat(4, tag, 64'h1C1D_1E1F_0000_0000, 8'hF0, 1'b1, 32'h0024_0800);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    dyn_src_ip = 32'h0; dyn_src_valid = 1'b0;
    dyn_dst_ip = 32'h0; dyn_dst_valid = 1'b0;
    s_data = 64'h0; s_user = 56'h0; s_keep = 8'h0; s_last = 1'b0; s_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {127'h0, m_valid}, 128'h0);
    chk("rst_data",  {64'h0, m_data},   128'h0);
    chk("rst_keep",  {120'h0, m_keep},  128'h0);
    chk("rst_last",  {127'h0, m_last},  128'h0);
    chk("rst_user",  {96'h0, m_user},   128'h0);
    chk("rst_sready", {127'h0, s_ready}, 128'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic 16-byte packet, ready held high.
    s_user = mk_user(16'd16, 3'b010, 8'd17, 13'd0, 16'd0);
    t0 = cyc;
    send_pkt16();
    expect_beats(5, "basic");
    check_pkt16(64'h4011_F0B0_C0A8_6463, "basic");
    chk("basic_latency", 128'(q[0].c), 128'(t0 + 2));
    chk("basic_nobubble", 128'(q[4].c - q[0].c), 128'd4);
    q.delete();

    // 12-byte payload: last beat keep F0, no tail word.
    s_user = mk_user(16'd12, 3'b010, 8'd17, 13'd0, 16'd0);
    send_beat(64'h1011121314151617, 8'hFF, 1'b0);
    send_beat(64'h18191A1B00000000, 8'hF0, 1'b1);
    expect_beats(4, "p12");
    check_beat(0, "p12", 64'h4500_0020_0000_4000, 8'hFF, 1'b0, 32'h0020_0800);
    check_beat(1, "p12", 64'h4011_F0B4_C0A8_6463, 8'hFF, 1'b0, 32'h0020_0800);
    check_beat(2, "p12", 64'hC0A8_6464_1011_1213, 8'hFF, 1'b0, 32'h0020_0800);
    check_beat(3, "p12", 64'h1415_1617_1819_1A1B, 8'hFF, 1'b1, 32'h0020_0800);
    q.delete();

    // 13-byte payload: last beat keep F8, tail word keep 80.
    s_user = mk_user(16'd13, 3'b010, 8'd17, 13'd0, 16'd0);
    send_beat(64'h1011121314151617, 8'hFF, 1'b0);
    send_beat(64'h18191A1B1C000000, 8'hF8, 1'b1);
    expect_beats(5, "p13");
    check_beat(0, "p13", 64'h4500_0021_0000_4000, 8'hFF, 1'b0, 32'h0021_0800);
    check_beat(1, "p13", 64'h4011_F0B3_C0A8_6463, 8'hFF, 1'b0, 32'h0021_0800);
    check_beat(2, "p13", 64'hC0A8_6464_1011_1213, 8'hFF, 1'b0, 32'h0021_0800);
    check_beat(3, "p13", 64'h1415_1617_1819_1A1B, 8'hFF, 1'b0, 32'h0021_0800);
    check_beat(4, "p13", 64'h1C00_0000_0000_0000, 8'h80, 1'b1, 32'h0021_0800);
    q.delete();

    // Random backpressure: same stream as the basic packet.
    s_user = mk_user(16'd16, 3'b010, 8'd17, 13'd0, 16'd0);
    bp_en = 1'b1;
    send_pkt16();
    expect_beats(5, "bp");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_pkt16(64'h4011_F0B0_C0A8_6463, "bp");
    q.delete();

    // Source IP changed mid-packet: current packet unaffected, next one uses it.
    send_beat(64'h1011121314151617, 8'hFF, 1'b0);
    dyn_src_ip    = 32'h0A00_0001;
    dyn_src_valid = 1'b1;
    send_beat(64'h18191A1B1C1D1E1F, 8'hFF, 1'b1);
    dyn_src_valid = 1'b0;
    expect_beats(5, "dyn_cur");
    check_pkt16(64'h4011_F0B0_C0A8_6463, "dyn_cur");
    q.delete();
    send_pkt16();
    expect_beats(5, "dyn_next");
    check_pkt16(64'h4011_0BBC_0A00_0001, "dyn_next");
    q.delete();

    // Reset while in DATA: outputs clear at once, next packet starts from W0.
    send_beat(64'h1011121314151617, 8'hFF, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {127'h0, m_valid}, 128'h0);
    chk("mid_rst_data",  {64'h0, m_data},   128'h0);
    chk("mid_rst_keep",  {120'h0, m_keep},  128'h0);
    chk("mid_rst_last",  {127'h0, m_last},  128'h0);
    chk("mid_rst_user",  {96'h0, m_user},   128'h0);
    chk("mid_rst_sready", {127'h0, s_ready}, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
    send_pkt16();
    expect_beats(5, "post_rst");
    check_pkt16(64'h4011_F0B0_C0A8_6463, "post_rst");
    chk("post_rst_latency", 128'(q[0].c), 128'(t0 + 2));
    q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
